i2c_register_responder: RTL and testbench

I2C_REGISTER_RESPONDER -- requirements
Module: i2c_register_responder

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_sync.sv | 49 ++++
 rtl/i2c_register_responder.sv | 187 ++++++++++++++++++
 tb/tb_i2c_register_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register responder: FSM states,
// default target address and read-data latency.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REGH,
        ST_REGH_ACK,
        ST_REGL,
        ST_REGL_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic [6:0] DEFAULT_DEV_ID = 7'h24;
    localparam int         RD_LATENCY     = 2;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA into the system clock and derives SCL edges
// plus START/STOP conditions from the synchronized values only.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl;

    // Idle bus level is high, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync[0] <= scl_in;
            sda_sync[0] <= sda_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync[i] <= scl_sync[i-1];
                sda_sync[i] <= sda_sync[i-1];
            end
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_hist;
    assign scl_fall  = ~scl & scl_hist;
    assign start_det = scl & scl_hist & sda_hist & ~sda;
    assign stop_det  = scl & scl_hist & ~sda_hist & sda;

endmodule

// File: rtl/i2c_register_responder.sv
// I2C target exposing a 16-bit register address space: writes become
// wr_valid pulses, reads are fetched through rd_req/rd_data.
module i2c_register_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = DEFAULT_DEV_ID,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy
);

    localparam logic [1:0] RD_WAIT = 2'(RD_LATENCY + 1);

    state_t      state, state_next;
    logic        sda, scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [15:0] pointer;
    logic        ack_phase, rw_bit;
    logic [1:0]  rd_wait;
    logic        shift_en, byte_done, ack_start, ack_end, issue_rd, tx_step, rd_ack;
    logic [7:0]  rx_byte;
    logic        addr_hit;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign rx_byte   = {shift[6:0], sda};
    assign addr_hit  = (rx_byte[7:1] == DEV_ID);
    assign byte_done = shift_en && (bit_cnt == 3'd7);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = ST_IDLE;
        end else if (start_det) begin
            state_next = ST_ADDR;
        end else begin
            case (state)
                ST_ADDR:      if (byte_done) state_next = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
                ST_REGH:      if (byte_done) state_next = ST_REGH_ACK;
                ST_REGL:      if (byte_done) state_next = ST_REGL_ACK;
                ST_WDATA:     if (byte_done) state_next = ST_WDATA_ACK;
                ST_ADDR_ACK:  if (ack_end) state_next = rw_bit ? ST_RDATA : ST_REGH;
                ST_REGH_ACK:  if (ack_end) state_next = ST_REGL;
                ST_REGL_ACK,
                ST_WDATA_ACK: if (ack_end) state_next = ST_WDATA;
                ST_RDATA:     if (tx_step && bit_cnt == 3'd7) state_next = ST_RDATA_ACK;
                ST_RDATA_ACK: begin
                    if (scl_rise && sda) state_next = ST_IGNORE;
                    else if (issue_rd)   state_next = ST_RDATA;
                end
                default: ;
            endcase
        end
    end

    // Bus conditions outrank any SCL edge seen in the same clock.
    always_comb begin
        shift_en  = 1'b0;
        ack_start = 1'b0;
        ack_end   = 1'b0;
        issue_rd  = 1'b0;
        tx_step   = 1'b0;
        rd_ack    = 1'b0;
        if (!start_det && !stop_det) begin
            case (state)
                ST_ADDR, ST_REGH, ST_REGL, ST_WDATA: shift_en = scl_rise;
                ST_ADDR_ACK, ST_REGH_ACK, ST_REGL_ACK, ST_WDATA_ACK: begin
                    ack_start = scl_fall && !ack_phase;
                    ack_end   = scl_fall && ack_phase;
                    issue_rd  = scl_fall && ack_phase && (state == ST_ADDR_ACK) && rw_bit;
                end
                ST_RDATA:     tx_step = scl_fall && (rd_wait == 2'd0);
                ST_RDATA_ACK: begin
                    rd_ack   = scl_rise && !sda;
                    issue_rd = scl_fall && ack_phase;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sda_oe    <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            pointer   <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            ack_phase <= 1'b0;
            rw_bit    <= 1'b0;
            rd_wait   <= '0;
        end else begin
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            if (start_det || stop_det) begin
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
                rd_wait   <= '0;
                bit_cnt   <= '0;
                if (stop_det) busy <= 1'b0;
            end else begin
                if (shift_en) begin
                    shift   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        ST_ADDR: begin
                            busy   <= addr_hit;
                            rw_bit <= sda;
                        end
                        ST_REGH:  pointer[15:8] <= rx_byte;
                        ST_REGL:  pointer[7:0]  <= rx_byte;
                        ST_WDATA: begin
                            wr_valid <= 1'b1;
                            wr_addr  <= pointer;
                            wr_data  <= rx_byte;
                            pointer  <= pointer + 16'd1;
                        end
                        default: ;
                    endcase
                end
                if (ack_start) begin
                    sda_oe    <= 1'b1;
                    ack_phase <= 1'b1;
                end
                if (ack_end) begin
                    sda_oe    <= 1'b0;
                    ack_phase <= 1'b0;
                end
                if (rd_ack) ack_phase <= 1'b1;
                if (issue_rd) begin
                    rd_req    <= 1'b1;
                    rd_addr   <= pointer;
                    rd_wait   <= RD_WAIT;
                    bit_cnt   <= '0;
                    ack_phase <= 1'b0;
                end
                if (rd_wait != 2'd0) rd_wait <= rd_wait - 2'd1;
                // MSB goes out as soon as the byte arrives; SCL is still low.
                if (rd_wait == 2'd1) begin
                    shift   <= rd_data;
                    sda_oe  <= ~rd_data[7];
                    pointer <= pointer + 16'd1;
                end
                if (tx_step) begin
                    sda_oe  <= (bit_cnt == 3'd7) ? 1'b0 : ~shift[6];
                    shift   <= {shift[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_register_responder.sv
// Directed bench for i2c_register_responder: bit-banged I2C master at
// ~100 kHz on a 12.5 MHz clock, with a small register-read model.
module tb_i2c_register_responder;

    localparam time CLK_HALF = 40ns;
    localparam time Q        = 2500ns;

    logic        clock, reset_n, scl_in, sda_m, sda_in;
    logic        sda_oe, wr_valid, rd_req, busy;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data;

    int          checks, failures, viol, oe_cnt, busy_cnt;
    logic [23:0] wr_log[$];
    logic [15:0] rd_log[$];
    logic        oe_prev, scl_prev, rst_prev;

    assign sda_in = sda_m & ~sda_oe;

    i2c_register_responder #(.DEV_ID(7'h24), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #CLK_HALF clock = ~clock;

    // Observers on the inactive edge; also flags SDA drive changes while SCL is high.
    initial begin
        viol = 0; oe_cnt = 0; busy_cnt = 0;
        oe_prev = 1'b0; scl_prev = 1'b1; rst_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (wr_valid) wr_log.push_back({wr_addr, wr_data});
            if (sda_oe) oe_cnt++;
            if (busy) busy_cnt++;
            if (reset_n && rst_prev && scl_in && scl_prev && (sda_oe !== oe_prev)) begin
                viol++;
                $display("FAIL sda_oe_change_scl_high got=%b was=%b t=%0t", sda_oe, oe_prev, $time);
            end
            oe_prev = sda_oe; scl_prev = scl_in; rst_prev = reset_n;
        end
    end

    // Register read model: answers each rd_req half a clock later.
    initial begin
        rd_data = 8'h00;
        forever begin
            @(negedge clock);
            if (rd_req) begin
                rd_log.push_back(rd_addr);
                rd_data = (rd_addr == 16'h3000) ? 8'hA5 :
                          (rd_addr == 16'h3001) ? 8'h3C : 8'hEE;
            end
        end
    end

    task automatic write_bit(input logic b);
        sda_m = b; #Q; scl_in = 1'b1; #(2*Q); scl_in = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q; scl_in = 1'b1; #Q; b = sda_in; #Q; scl_in = 1'b0; #Q;
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; #Q; scl_in = 1'b1; #Q; sda_m = 1'b0; #Q; scl_in = 1'b0; #Q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; #Q; scl_in = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(master_ack);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; scl_in = 1'b1; sda_m = 1'b1;
        repeat (4) @(negedge clock);
        #1ns;
        checks++; if (sda_oe !== 1'b0)    begin failures++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
        checks++; if (wr_valid !== 1'b0)  begin failures++; $display("FAIL rst_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (rd_req !== 1'b0)    begin failures++; $display("FAIL rst_rd_req got=%b exp=0", rd_req); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (wr_addr !== 16'h0)  begin failures++; $display("FAIL rst_wr_addr got=%h exp=0000", wr_addr); end
        checks++; if (wr_data !== 8'h0)   begin failures++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
        checks++; if (rd_addr !== 16'h0)  begin failures++; $display("FAIL rst_rd_addr got=%h exp=0000", rd_addr); end
        reset_n = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic test_write_single;
        logic [7:0] seq [4];
        logic ack;
        int base;
        seq = '{8'h48, 8'h01, 8'h03, 8'h5A};
        base = wr_log.size();
        i2c_start;
        foreach (seq[i]) begin
            send_byte(seq[i], ack);
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wr1_ack%0d got=%b exp=0", i, ack); end
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wr1_busy_mid got=%b exp=1", busy); end
        i2c_stop;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr1_busy_stop got=%b exp=0", busy); end
        checks++; if (wr_log.size() - base != 1) begin failures++; $display("FAIL wr1_count got=%0d exp=1", wr_log.size() - base); end
        checks++; if (wr_log.size() <= base || wr_log[base] !== 24'h01035A) begin
            failures++; $display("FAIL wr1_entry got=%h exp=01035a", (wr_log.size() > base) ? wr_log[base] : 24'hx);
        end
    endtask

    task automatic test_pointer_wrap;
        logic [7:0] seq [5];
        logic ack;
        int base;
        seq = '{8'h48, 8'hFF, 8'hFF, 8'h11, 8'h22};
        base = wr_log.size();
        i2c_start;
        foreach (seq[i]) begin
            send_byte(seq[i], ack);
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wrap_ack%0d got=%b exp=0", i, ack); end
        end
        i2c_stop;
        checks++; if (wr_log.size() - base != 2) begin failures++; $display("FAIL wrap_count got=%0d exp=2", wr_log.size() - base); end
        checks++; if (wr_log.size() <= base || wr_log[base] !== 24'hFFFF11) begin
            failures++; $display("FAIL wrap_entry0 got=%h exp=ffff11", (wr_log.size() > base) ? wr_log[base] : 24'hx);
        end
        checks++; if (wr_log.size() <= base + 1 || wr_log[base+1] !== 24'h000022) begin
            failures++; $display("FAIL wrap_entry1 got=%h exp=000022", (wr_log.size() > base + 1) ? wr_log[base+1] : 24'hx);
        end
    endtask

    task automatic test_addr_mismatch;
        logic [7:0] seq [4];
        logic ack;
        int wbase, obase, bbase;
        seq = '{8'h4A, 8'h01, 8'h02, 8'h03};
        wbase = wr_log.size(); obase = oe_cnt; bbase = busy_cnt;
        i2c_start;
        foreach (seq[i]) begin
            send_byte(seq[i], ack);
            checks++; if (ack !== 1'b1) begin failures++; $display("FAIL miss_ack%0d got=%b exp=1", i, ack); end
        end
        i2c_stop;
        checks++; if (oe_cnt != obase)      begin failures++; $display("FAIL miss_sda_oe cycles=%0d exp=0", oe_cnt - obase); end
        checks++; if (busy_cnt != bbase)    begin failures++; $display("FAIL miss_busy cycles=%0d exp=0", busy_cnt - bbase); end
        checks++; if (wr_log.size() != wbase) begin failures++; $display("FAIL miss_wr_count got=%0d exp=0", wr_log.size() - wbase); end
    endtask

    task automatic test_read_restart;
        logic [7:0] seq [3];
        logic [7:0] d0, d1;
        logic ack;
        int rbase, wbase;
        seq = '{8'h48, 8'h30, 8'h00};
        rbase = rd_log.size(); wbase = wr_log.size();
        i2c_start;
        foreach (seq[i]) begin
            send_byte(seq[i], ack);
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rd_setup_ack%0d got=%b exp=0", i, ack); end
        end
        i2c_start;
        send_byte(8'h49, ack);
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        i2c_stop;
        checks++; if (d0 !== 8'hA5) begin failures++; $display("FAIL rd_byte0 got=%h exp=a5", d0); end
        checks++; if (d1 !== 8'h3C) begin failures++; $display("FAIL rd_byte1 got=%h exp=3c", d1); end
        checks++; if (rd_log.size() - rbase != 2) begin failures++; $display("FAIL rd_req_count got=%0d exp=2", rd_log.size() - rbase); end
        checks++; if (rd_log.size() <= rbase || rd_log[rbase] !== 16'h3000) begin
            failures++; $display("FAIL rd_addr0 got=%h exp=3000", (rd_log.size() > rbase) ? rd_log[rbase] : 16'hx);
        end
        checks++; if (rd_log.size() <= rbase + 1 || rd_log[rbase+1] !== 16'h3001) begin
            failures++; $display("FAIL rd_addr1 got=%h exp=3001", (rd_log.size() > rbase + 1) ? rd_log[rbase+1] : 16'hx);
        end
        checks++; if (wr_log.size() != wbase) begin failures++; $display("FAIL rd_wr_count got=%0d exp=0", wr_log.size() - wbase); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic test_reset_during_ack;
        logic [7:0] a;
        a = 8'h48;
        i2c_start;
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        sda_m = 1'b1; #Q; scl_in = 1'b1; #Q;
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rack_drive got=%b exp=1", sda_oe); end
        @(negedge clock); #5ns;
        reset_n = 1'b0;
        #1ns;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rack_async_release got=%b exp=0", sda_oe); end
        #Q; scl_in = 1'b0; #Q;
        reset_n = 1'b1;
        #Q;
        i2c_stop;
    endtask

    task automatic test_reset_mid_byte;
        logic [7:0] seq [3];
        logic [7:0] seq2 [4];
        logic [7:0] d;
        logic ack;
        int wbase, obase;
        seq  = '{8'h48, 8'h00, 8'h10};
        seq2 = '{8'h48, 8'h00, 8'h20, 8'h77};
        d = 8'hC3;
        wbase = wr_log.size();
        i2c_start;
        foreach (seq[i]) begin
            send_byte(seq[i], ack);
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rmid_ack%0d got=%b exp=0", i, ack); end
        end
        for (int i = 7; i >= 4; i--) write_bit(d[i]);
        sda_m = d[3]; #Q; scl_in = 1'b1; #Q;
        @(negedge clock); #5ns;
        reset_n = 1'b0;
        #1ns;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rmid_sda_oe got=%b exp=0", sda_oe); end
        #Q; scl_in = 1'b0; #Q;
        reset_n = 1'b1;
        obase = oe_cnt;
        for (int i = 2; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rmid_junk_ack got=%b exp=1", ack); end
        checks++; if (oe_cnt != obase) begin failures++; $display("FAIL rmid_junk_oe cycles=%0d exp=0", oe_cnt - obase); end
        checks++; if (wr_log.size() != wbase) begin failures++; $display("FAIL rmid_wr_count got=%0d exp=0", wr_log.size() - wbase); end
        i2c_start;
        foreach (seq2[i]) begin
            send_byte(seq2[i], ack);
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rmid_post_ack%0d got=%b exp=0", i, ack); end
        end
        i2c_stop;
        checks++; if (wr_log.size() <= wbase || wr_log[wbase] !== 24'h002077) begin
            failures++; $display("FAIL rmid_post_entry got=%h exp=002077", (wr_log.size() > wbase) ? wr_log[wbase] : 24'hx);
        end
    endtask

    task automatic test_stop_mid_byte;
        logic [7:0] seq [3];
        logic ack;
        int wbase;
        seq = '{8'h48, 8'h00, 8'h40};
        wbase = wr_log.size();
        i2c_start;
        foreach (seq[i]) begin
            send_byte(seq[i], ack);
            checks++; if (ack !== 1'b0) begin failures++; $display("FAIL smid_ack%0d got=%b exp=0", i, ack); end
        end
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
        i2c_stop;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL smid_busy got=%b exp=0", busy); end
        checks++; if (wr_log.size() != wbase) begin failures++; $display("FAIL smid_wr_count got=%0d exp=0", wr_log.size() - wbase); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL smid_sda_oe got=%b exp=0", sda_oe); end
        checks++; if (viol != 0) begin failures++; $display("FAIL sda_oe_scl_high_total got=%0d exp=0", viol); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset_n = 1'b0; scl_in = 1'b1; sda_m = 1'b1;
        test_reset;
        test_write_single;
        test_pointer_wrap;
        test_addr_mismatch;
        test_read_restart;
        test_reset_during_ack;
        test_reset_mid_byte;
        test_stop_mid_byte;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
